// File: rtl/draw_grid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : draw_grid_tracker
// Purpose  : Tracks a raster pixel stream against a brick-wall playfield
//            (borders between bricks) using per-axis segment counters and
//            reports field/brick membership, brick indices and in-brick
//            offsets one cycle after each valid pixel.
// Options  : DRAW_GRID_TRACKER_SYNC_CHECK_EN - enables the raster
//            discontinuity detector driving sync_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module draw_grid_tracker #(
    parameter int PIX_WIDTH   = 12,
    parameter int BRICK_X     = 20,
    parameter int BRICK_Y     = 25,
    parameter int BRICK_X_CNT = 10,
    parameter int BRICK_Y_CNT = 20,
    parameter int BORDER_X    = 2,
    parameter int BORDER_Y    = 2
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [PIX_WIDTH-1:0]                           start_x_i,
    input  logic [PIX_WIDTH-1:0]                           start_y_i,
    output logic [PIX_WIDTH-1:0]                           end_x_o,
    output logic [PIX_WIDTH-1:0]                           end_y_o,
    input  logic                                           pix_valid_i,
    input  logic [PIX_WIDTH-1:0]                           pix_x_i,
    input  logic [PIX_WIDTH-1:0]                           pix_y_i,
    output logic                                           in_field_o,
    output logic                                           in_brick_o,
    output logic [$clog2(BRICK_X_CNT)-1:0]                 brick_col_num_o,
    output logic [$clog2(BRICK_Y_CNT)-1:0]                 brick_row_num_o,
    output logic [((BRICK_X > 1) ? $clog2(BRICK_X) : 1)-1:0] brick_pix_x_o,
    output logic [((BRICK_Y > 1) ? $clog2(BRICK_Y) : 1)-1:0] brick_pix_y_o,
    output logic                                           out_valid_o,
    output logic                                           sync_err_o
);

    localparam int COL_W   = $clog2(BRICK_X_CNT);
    localparam int ROW_W   = $clog2(BRICK_Y_CNT);
    // Internal indices must also hold the count value reached in the last border.
    localparam int COLI_W  = $clog2(BRICK_X_CNT + 1);
    localparam int ROWI_W  = $clog2(BRICK_Y_CNT + 1);
    localparam int OFSX_W  = (BRICK_X > 1) ? $clog2(BRICK_X) : 1;
    localparam int OFSY_W  = (BRICK_Y > 1) ? $clog2(BRICK_Y) : 1;
    localparam int XSEG    = (BRICK_X > BORDER_X) ? BRICK_X : BORDER_X;
    localparam int YSEG    = (BRICK_Y > BORDER_Y) ? BRICK_Y : BORDER_Y;
    localparam int XCNT_W  = $clog2(XSEG + 1);
    localparam int YCNT_W  = $clog2(YSEG + 1);
    localparam int X_SPAN  = BORDER_X * (BRICK_X_CNT + 1) + BRICK_X * BRICK_X_CNT - 1;
    localparam int Y_SPAN  = BORDER_Y * (BRICK_Y_CNT + 1) + BRICK_Y * BRICK_Y_CNT - 1;

    typedef enum logic [1:0] {
        AX_OUTSIDE = 2'd0,
        AX_BORDER  = 2'd1,
        AX_BRICK   = 2'd2,
        AX_DONE    = 2'd3
    } axis_state_t;

    axis_state_t         x_state, x_state_nx, y_state, y_state_nx;
    logic [XCNT_W-1:0]   x_cnt, x_cnt_nx;
    logic [YCNT_W-1:0]   y_cnt, y_cnt_nx;
    logic [COLI_W-1:0]   x_col, x_col_nx;
    logic [ROWI_W-1:0]   y_row, y_row_nx;
    logic                line_evt;
    logic                x_slip;
    logic                x_in_field, y_in_field, x_in_brick, y_in_brick;

    // Field corner is pure modular arithmetic, so wrapped fields come out right.
    assign end_x_o  = start_x_i + PIX_WIDTH'(X_SPAN);
    assign end_y_o  = start_y_i + PIX_WIDTH'(Y_SPAN);
    assign line_evt = pix_valid_i && (pix_x_i == start_x_i);

`ifdef DRAW_GRID_TRACKER_SYNC_CHECK_EN
    logic [PIX_WIDTH-1:0] prev_x;
    logic                 sync_err;

    assign x_slip = pix_valid_i
                 && (pix_x_i != prev_x + PIX_WIDTH'(1))
                 && (pix_x_i != start_x_i)
                 && ((x_state == AX_BORDER) || (x_state == AX_BRICK));
    assign sync_err_o = sync_err;

    // Remember the last valid x and latch any discontinuity until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_x   <= '0;
            sync_err <= 1'b0;
        end else if (pix_valid_i) begin
            prev_x   <= pix_x_i;
            sync_err <= sync_err | x_slip;
        end
    end
`else
    assign x_slip     = 1'b0;
    assign sync_err_o = 1'b0;
`endif

    // Axis state registers; they only move on valid pixels / line events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_state <= AX_OUTSIDE;
            x_cnt   <= '0;
            x_col   <= '0;
            y_state <= AX_OUTSIDE;
            y_cnt   <= '0;
            y_row   <= '0;
        end else begin
            x_state <= x_state_nx;
            x_cnt   <= x_cnt_nx;
            x_col   <= x_col_nx;
            y_state <= y_state_nx;
            y_cnt   <= y_cnt_nx;
            y_row   <= y_row_nx;
        end
    end

    // X axis: classify the current pixel by advancing one position per valid pixel.
    always_comb begin
        x_state_nx = x_state;
        x_cnt_nx   = x_cnt;
        x_col_nx   = x_col;
        if (pix_valid_i) begin
            if (pix_x_i == start_x_i) begin
                x_state_nx = AX_BORDER;
                x_cnt_nx   = '0;
                x_col_nx   = '0;
            end else if (x_slip) begin
                x_state_nx = AX_OUTSIDE;
                x_cnt_nx   = '0;
                x_col_nx   = '0;
            end else begin
                case (x_state)
                    AX_BORDER: begin
                        if (x_cnt == XCNT_W'(BORDER_X - 1)) begin
                            x_cnt_nx   = '0;
                            x_state_nx = (x_col < COLI_W'(BRICK_X_CNT)) ? AX_BRICK : AX_DONE;
                        end else begin
                            x_cnt_nx = x_cnt + XCNT_W'(1);
                        end
                    end
                    AX_BRICK: begin
                        if (x_cnt == XCNT_W'(BRICK_X - 1)) begin
                            x_state_nx = AX_BORDER;
                            x_cnt_nx   = '0;
                            x_col_nx   = x_col + COLI_W'(1);
                        end else begin
                            x_cnt_nx = x_cnt + XCNT_W'(1);
                        end
                    end
                    default: begin
                        x_state_nx = AX_OUTSIDE;
                        x_cnt_nx   = '0;
                        x_col_nx   = '0;
                    end
                endcase
            end
        end
    end

    // Y axis: same sequencing, but steps only on a line event.
    always_comb begin
        y_state_nx = y_state;
        y_cnt_nx   = y_cnt;
        y_row_nx   = y_row;
        if (line_evt) begin
            if (pix_y_i == start_y_i) begin
                y_state_nx = AX_BORDER;
                y_cnt_nx   = '0;
                y_row_nx   = '0;
            end else begin
                case (y_state)
                    AX_BORDER: begin
                        if (y_cnt == YCNT_W'(BORDER_Y - 1)) begin
                            y_cnt_nx   = '0;
                            y_state_nx = (y_row < ROWI_W'(BRICK_Y_CNT)) ? AX_BRICK : AX_DONE;
                        end else begin
                            y_cnt_nx = y_cnt + YCNT_W'(1);
                        end
                    end
                    AX_BRICK: begin
                        if (y_cnt == YCNT_W'(BRICK_Y - 1)) begin
                            y_state_nx = AX_BORDER;
                            y_cnt_nx   = '0;
                            y_row_nx   = y_row + ROWI_W'(1);
                        end else begin
                            y_cnt_nx = y_cnt + YCNT_W'(1);
                        end
                    end
                    default: begin
                        y_state_nx = AX_OUTSIDE;
                        y_cnt_nx   = '0;
                        y_row_nx   = '0;
                    end
                endcase
            end
        end
    end

    assign x_in_brick = (x_state_nx == AX_BRICK);
    assign y_in_brick = (y_state_nx == AX_BRICK);
    assign x_in_field = (x_state_nx == AX_BORDER) || x_in_brick;
    assign y_in_field = (y_state_nx == AX_BORDER) || y_in_brick;

    // Register the decode of the pixel presented this cycle; idle cycles report nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o     <= 1'b0;
            in_field_o      <= 1'b0;
            in_brick_o      <= 1'b0;
            brick_col_num_o <= '0;
            brick_row_num_o <= '0;
            brick_pix_x_o   <= '0;
            brick_pix_y_o   <= '0;
        end else begin
            out_valid_o     <= pix_valid_i;
            in_field_o      <= pix_valid_i && x_in_field && y_in_field;
            in_brick_o      <= pix_valid_i && x_in_brick && y_in_brick;
            brick_col_num_o <= (pix_valid_i && x_in_brick) ? x_col_nx[COL_W-1:0]     : '0;
            brick_row_num_o <= (pix_valid_i && y_in_brick) ? y_row_nx[ROW_W-1:0]     : '0;
            brick_pix_x_o   <= (pix_valid_i && x_in_brick) ? x_cnt_nx[OFSX_W-1:0]    : '0;
            brick_pix_y_o   <= (pix_valid_i && y_in_brick) ? y_cnt_nx[OFSY_W-1:0]    : '0;
        end
    end

endmodule
`default_nettype wire
